// File: rtl/mod_addsub_pkg.sv
// Shared widths and FSM encoding for the modular add/subtract block.
package mod_addsub_pkg;

  localparam int WIDTH_DEF = 512;
  localparam int ADD_W_DEF = WIDTH_DEF + 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_W1   = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_W2   = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    P1   = ST_P1,
    W1   = ST_W1,
    P2   = ST_P2,
    W2   = ST_W2,
    FIN  = ST_FIN
  } state_t;

  // Lane width needed to hold a+b (< 2M) plus one guard bit.
  function automatic int add_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mod_addsub_mpadder.sv
// Multi-precision adder: operands captured on start, C = A +/- B one cycle later with a done pulse.
module mod_addsub_mpadder
  import mod_addsub_pkg::*;
#(
  parameter int ADD_W = ADD_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             subtract,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  output logic [ADD_W:0]   C,
  output logic             done
);

  logic [ADD_W-1:0] a_reg;
  logic [ADD_W-1:0] b_reg;
  logic             sub_reg;
  logic             run_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      run_reg <= 1'b0;
      C       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_reg   <= A;
        b_reg   <= B;
        sub_reg <= subtract;
        run_reg <= 1'b1;
      end else if (run_reg) begin
        run_reg <= 1'b0;
        done    <= 1'b1;
        // Extra top bit is the carry (add) or the two's complement sign (sub).
        C <= sub_reg ? ({1'b0, a_reg} - {1'b0, b_reg})
                     : ({1'b0, a_reg} + {1'b0, b_reg});
      end
    end
  end

endmodule

// File: rtl/mod_addsub.sv
// Modular add/subtract: raw mpadder pass followed by a +/-M correction pass.
module mod_addsub
  import mod_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int ADD_W = add_w(WIDTH);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, m_reg;
  logic             sub_reg;
  logic [ADD_W:0]   c1_reg;
  logic [WIDTH-1:0] result_reg;

  logic             mp_start;
  logic             mp_sub;
  logic [ADD_W-1:0] mp_a;
  logic [ADD_W-1:0] mp_b;
  logic [ADD_W:0]   mp_c;
  logic             mp_done;
  logic             pass2;
  logic [WIDTH-1:0] pick;
  logic             unused_mp_c;

  assign unused_mp_c = ^mp_c[ADD_W-1:WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = P1;
      P1:      state_next = W1;
      W1:      if (mp_done) state_next = P2;
      P2:      state_next = W2;
      W2:      if (mp_done) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Second pass works on C1 against M, with the opposite operation.
  always_comb begin
    pass2    = (state_reg == P2) || (state_reg == W2);
    mp_start = (state_reg == P1) || (state_reg == P2);
    mp_a     = pass2 ? c1_reg[ADD_W-1:0] : {2'b00, a_reg};
    mp_b     = pass2 ? {2'b00, m_reg} : {2'b00, b_reg};
    mp_sub   = pass2 ? ~sub_reg : sub_reg;
  end

  // add: keep S unless S-M is non-negative; sub: take D+M only when D was negative.
  always_comb begin
    if (sub_reg) begin
      pick = c1_reg[ADD_W] ? mp_c[WIDTH-1:0] : c1_reg[WIDTH-1:0];
    end else begin
      pick = mp_c[ADD_W] ? c1_reg[WIDTH-1:0] : mp_c[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      sub_reg    <= 1'b0;
      c1_reg     <= '0;
      result_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_reg   <= in_a;
        b_reg   <= in_b;
        m_reg   <= in_m;
        sub_reg <= subtract;
      end
      if (state_reg == W1 && mp_done) begin
        c1_reg <= mp_c;
      end
      if (state_reg == W2 && mp_done) begin
        result_reg <= pick;
      end
    end
  end

  assign result = result_reg;
  assign done   = (state_reg == FIN);
  assign busy   = (state_reg == P1) || (state_reg == W1) ||
                  (state_reg == P2) || (state_reg == W2);

  mod_addsub_mpadder #(
    .ADD_W(ADD_W)
  ) u_mpadder (
    .clk     (clk),
    .rstn    (rstn),
    .start   (mp_start),
    .subtract(mp_sub),
    .A       (mp_a),
    .B       (mp_b),
    .C       (mp_c),
    .done    (mp_done)
  );

endmodule

// File: tb/tb_mod_addsub.sv
// Directed bench for mod_addsub: modular add/sub vectors, latency, start isolation and mid-run reset.
module tb_mod_addsub;

  localparam int W       = 512;
  localparam int LAT     = 6;
  localparam int TIMEOUT = 50;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_m;
  logic [W-1:0] result;
  logic         done;
  logic         busy;

  int errors;
  int checks;

  mod_addsub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .subtract(subtract),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_m    (in_m),
    .result  (result),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns cycles from the start edge to the first sample with done high, -1 on timeout.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int n = 1; n <= TIMEOUT; n++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat  = n;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input bit sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic [W-1:0] exp);
    int lat;
    @(negedge clk);
    subtract = sub;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, W'(busy), W'(1));
    wait_done(lat);
    chk({tag, "_lat"}, W'(lat), W'(LAT));
    chk({tag, "_res"}, result, exp);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, W'(done), W'(0));
    chk({tag, "_busy_after"}, W'(busy), W'(0));
    $display("op %s sub=%0d a=%0h b=%0h m=%0h result=%0h lat=%0d", tag, sub, a, b, m, result, lat);
  endtask

  initial begin
    int lat;
    int dcount;
    logic [W-1:0] m17;
    logic [W-1:0] mbig;
    logic [W-1:0] mbig_m1;
    logic [W-1:0] mbig_m2;

    errors   = 0;
    checks   = 0;
    m17      = 512'h17;
    mbig     = {W{1'b1}};
    mbig_m1  = {{(W-4){1'b1}}, 4'hE};
    mbig_m2  = {{(W-4){1'b1}}, 4'hD};

    rstn     = 1'b0;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, '0);
    chk("reset_done", W'(done), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    @(negedge clk);
    rstn = 1'b1;

    run_op("add_5_7", 1'b0, 512'h05, 512'h07, m17, 512'h0C);
    run_op("add_14_0a", 1'b0, 512'h14, 512'h0A, m17, 512'h07);
    run_op("add_eq_m", 1'b0, 512'h0B, 512'h0C, m17, 512'h00);
    run_op("add_zero", 1'b0, 512'h00, 512'h00, m17, 512'h00);
    run_op("sub_wrap", 1'b1, 512'h03, 512'h0A, m17, 512'h10);
    run_op("sub_eq", 1'b1, 512'h0A, 512'h0A, m17, 512'h00);
    run_op("sub_16_1", 1'b1, 512'h16, 512'h01, m17, 512'h15);
    run_op("add_big", 1'b0, mbig_m1, mbig_m1, mbig, mbig_m2);
    run_op("sub_big", 1'b1, 512'h00, 512'h01, mbig, mbig_m1);

    // start held high; in_a changes while busy; back-to-back start right after done
    @(negedge clk);
    subtract = 1'b0;
    in_a     = 512'h05;
    in_b     = 512'h07;
    in_m     = m17;
    start    = 1'b1;
    @(posedge clk);
    #1;
    in_a = 512'h0F;
    wait_done(lat);
    chk("hold_lat", W'(lat), W'(LAT));
    chk("hold_res", result, 512'h0C);
    @(posedge clk);
    #1;
    chk("hold_idle_done", W'(done), W'(0));
    chk("hold_idle_busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept", W'(busy), W'(1));
    wait_done(lat);
    chk("b2b_lat", W'(lat), W'(LAT));
    chk("b2b_res", result, 512'h16);
    $display("op hold_b2b first=0c second=%0h lat=%0d", result, lat);

    // reset pulled during W1
    @(negedge clk);
    subtract = 1'b0;
    in_a     = 512'h05;
    in_b     = 512'h07;
    in_m     = m17;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_result", result, '0);
    chk("rst_mid_done", W'(done), W'(0));
    chk("rst_mid_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("rst_no_done", W'(dcount), W'(0));
    $display("op reset_mid_w1 spurious_done=%0d", dcount);
    run_op("post_rst_add", 1'b0, 512'h05, 512'h07, m17, 512'h0C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
